// File: rtl/stoch_matrix_mult_if.sv
// stoch_matrix_mult_seq_if: stream, flag and estimate signals of the stochastic matrix multiplier
interface stoch_matrix_mult_seq_if #(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_MID    = 2,
  parameter int NUM_COLS   = 2,
  parameter int STREAM_LEN = 256
);
  localparam int CW = $clog2(STREAM_LEN + 1);
  logic                            EN;
  logic                            CLEAR;
  logic [NUM_ROWS*NUM_MID-1:0]     A;
  logic [NUM_MID*NUM_COLS-1:0]     B;
  logic [NUM_ROWS*NUM_COLS-1:0]    Y;
  logic                            SAT;
  logic [NUM_ROWS*NUM_COLS*CW-1:0] EST;
  logic                            EST_VALID;
  modport master (output EN, CLEAR, A, B, input Y, SAT, EST, EST_VALID);
  modport slave  (input EN, CLEAR, A, B, output Y, SAT, EST, EST_VALID);
endinterface

// File: rtl/stoch_matrix_mult_seq.sv
// stoch_matrix_mult_seq: bitstream matrix product with remainder carry; window estimator built only
// when STOCH_MM_EST_EN is defined.
module stoch_matrix_mult_seq #(
  parameter int NUM_ROWS   = 2,
  parameter int NUM_MID    = 2,
  parameter int NUM_COLS   = 2,
  parameter int STREAM_LEN = 256
) (
  input logic CLK,
  input logic RST,
  stoch_matrix_mult_seq_if.slave io
);
  localparam int NE = NUM_ROWS * NUM_COLS;
  localparam int RW = $clog2(2 * NUM_MID + 1);
  localparam int CW = $clog2(STREAM_LEN + 1);
  localparam logic [RW:0] RMAX = (RW + 1)'(2 * NUM_MID);
  logic [RW-1:0] r_q [NE];
  logic [RW-1:0] r_d [NE];
  logic [RW:0]   tv  [NE];
  logic [RW:0]   dv  [NE];
  logic [NE-1:0] y_q, y_d, yv;
  logic          sat_q, sat_d;
  always_comb begin
    y_d   = '0;
    yv    = '0;
    sat_d = sat_q;
    r_d   = r_q;
    tv    = '{default: '0};
    dv    = '{default: '0};
    for (int k = 0; k < NE; k++) begin
      tv[k] = (RW + 1)'(r_q[k]);
      for (int m = 0; m < NUM_MID; m++)
        tv[k] = tv[k] + (RW + 1)'(io.A[(k / NUM_COLS) * NUM_MID + m] & io.B[m * NUM_COLS + k % NUM_COLS]);
      yv[k] = |tv[k];
      dv[k] = tv[k] - (RW + 1)'(yv[k]);
      if (io.EN) begin
        y_d[k] = yv[k];
        r_d[k] = dv[k] > RMAX ? RMAX[RW-1:0] : dv[k][RW-1:0];
        sat_d  = sat_d | (dv[k] > RMAX);
      end
    end
    if (io.CLEAR) begin
      y_d   = '0;
      sat_d = 1'b0;
      r_d   = '{default: '0};
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q   <= '0;
      sat_q <= 1'b0;
      r_q   <= '{default: '0};
    end else begin
      y_q   <= y_d;
      sat_q <= sat_d;
      r_q   <= r_d;
    end
  end
  assign io.Y   = y_q;
  assign io.SAT = sat_q;
`ifdef STOCH_MM_EST_EN
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] cnt_q [NE];
  logic [CW-1:0] cnt_d [NE];
  logic [CW-1:0] est_q [NE];
  logic [CW-1:0] est_d [NE];
  logic          est_valid_q, est_valid_d;
  always_comb begin
    win_d       = win_q;
    cnt_d       = cnt_q;
    est_d       = est_q;
    est_valid_d = 1'b0;
    if (io.CLEAR) begin
      win_d = '0;
      cnt_d = '{default: '0};
    end else if (io.EN) begin
      win_d = win_q == CW'(STREAM_LEN - 1) ? '0 : win_q + 1'b1;
      for (int k = 0; k < NE; k++) begin
        cnt_d[k] = win_q == CW'(STREAM_LEN - 1) ? '0 : cnt_q[k] + CW'(yv[k]);
        est_d[k] = win_q == CW'(STREAM_LEN - 1) ? cnt_q[k] + CW'(yv[k]) : est_q[k];
      end
      est_valid_d = win_q == CW'(STREAM_LEN - 1);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      win_q       <= '0;
      cnt_q       <= '{default: '0};
      est_q       <= '{default: '0};
      est_valid_q <= 1'b0;
    end else begin
      win_q       <= win_d;
      cnt_q       <= cnt_d;
      est_q       <= est_d;
      est_valid_q <= est_valid_d;
    end
  end
  for (genvar g = 0; g < NE; g++) assign io.EST[g*CW +: CW] = est_q[g];
  assign io.EST_VALID = est_valid_q;
`else
  assign io.EST       = {NE * CW{1'b0}};
  assign io.EST_VALID = 1'b0;
`endif
endmodule

// File: doc/stoch_matrix_mult_seq.md
STOCH_MATRIX_MULT_SEQ -- requirements
Module: stoch_matrix_mult_seq

Interface
REQ-001 SHALL have parameter NUM_ROWS, default 2, rows of A and Y.
REQ-002 SHALL have parameter NUM_MID, default 2, columns of A and rows of B.
REQ-003 SHALL have parameter NUM_COLS, default 2, columns of B and Y.
REQ-004 SHALL have parameter STREAM_LEN, default 256, enabled cycles per estimation window (>=2).
REQ-005 SHALL derive RW = $clog2(2*NUM_MID+1) (remainder width) and CW = $clog2(STREAM_LEN+1) (estimate width).
REQ-006 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-007 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-008 SHALL have port EN  input  1  consume one bit of every input stream this cycle.
REQ-009 SHALL have port CLEAR  input  1  synchronous clear of all arithmetic state.
REQ-010 SHALL have port A  input  NUM_ROWS*NUM_MID  row-major bitstreams; element (i,m) at bit i*NUM_MID+m.
REQ-011 SHALL have port B  input  NUM_MID*NUM_COLS  row-major bitstreams; element (m,j) at bit m*NUM_COLS+j.
REQ-012 SHALL have port Y  output  NUM_ROWS*NUM_COLS  registered product bitstreams; element (i,j) at bit i*NUM_COLS+j.
REQ-013 SHALL have port SAT  output  1  sticky flag: a remainder accumulator saturated.
REQ-014 SHALL have port EST  output  NUM_ROWS*NUM_COLS*CW  per-element ones count of last window; element k at [k*CW +: CW].
REQ-015 SHALL have port EST_VALID  output  1  one-cycle pulse when EST updates.

Function
REQ-016 Per element (i,j), each cycle s = popcount over m of A(i,m) AND B(m,j), range 0..NUM_MID.
REQ-017 Per element, RW-bit remainder R; on EN: t = R + s; y = (t >= 1); R <= min(t - y, 2*NUM_MID); Y(i,j) <= y.
REQ-018 On EN, if any element has t - y > 2*NUM_MID, SAT SHALL set and remain set until CLEAR or RST.
REQ-019 With EN low, Y SHALL be 0 next cycle and R, window counter, ones counters SHALL hold.
REQ-020 Latency: Y SHALL reflect inputs sampled at the previous rising edge (1 cycle).
REQ-021 Window counter SHALL count enabled cycles 0..STREAM_LEN-1 and wrap to 0.
REQ-022 Per element, CW-bit ones counter SHALL add y on each enabled cycle.
REQ-023 On the enabled cycle with window counter = STREAM_LEN-1: EST(k) <= count(k) + y(k), count(k) <= 0, EST_VALID <= 1; otherwise EST_VALID <= 0.
REQ-024 EST SHALL hold its value between windows.
REQ-025 Priority SHALL be RST > CLEAR > EN.
REQ-026 CLEAR SHALL zero R, Y, SAT, window counter, ones counters, EST_VALID; EST SHALL hold.

Reset
REQ-027 RST SHALL set Y=0, SAT=0, EST=0, EST_VALID=0, all R, window and ones counters to 0, at the next rising edge.
REQ-028 RST asserted mid-window SHALL discard the partial window; first EST_VALID occurs STREAM_LEN enabled cycles after RST deasserts.

Configuration
REQ-029 Macro STOCH_MM_EST_EN defined: window counter, ones counters, EST and EST_VALID SHALL be implemented per REQ-021..REQ-024.
REQ-030 Macro STOCH_MM_EST_EN undefined: those counters SHALL not be built, EST SHALL be constant 0, EST_VALID constant 0; ports unchanged, Y/SAT behaviour identical.

Verification (NUM_ROWS=NUM_MID=NUM_COLS=2, STREAM_LEN=8, STOCH_MM_EST_EN defined unless noted)
REQ-031 A=4'b1001, B=4'b0110, EN=1 for 8 cycles -> Y=4'b0110 from cycle 1, R stays 0, SAT=0, EST elements {0,8,8,0}, one EST_VALID pulse.
REQ-032 A=4'hF, B=4'hF, EN=1 -> Y=4'hF every cycle, R=1,2,3,4,4; SAT rises after 5th enabled cycle; EST all 8.
REQ-033 A=0, B=0, EN=1 for 24 cycles -> Y=0, EST all 0, EST_VALID pulses after enabled cycles 8, 16, 24.
REQ-034 A=4'hF, B=4'hF, EN toggling 1,0 -> Y alternates 1/0 per element, EST_VALID after 16 clocks (8 enabled), EST all 8.
REQ-035 CLEAR after 5 enabled cycles of REQ-032 stimulus -> SAT=0, R=0, Y=0 next cycle, EST unchanged; next EST_VALID 8 enabled cycles later; RST instead -> EST=0 too.
REQ-036 STOCH_MM_EST_EN undefined, REQ-032 stimulus -> Y and SAT identical, EST=0, EST_VALID never asserts.
